// File: rtl/led_rate_gen.sv
// Programmable divider producing the slow LED stepping clock and a tick strobe.
// Button inputs are synchronised and edge-detected to adjust the half-period at run time.
module led_rate_gen #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned DEFAULT_HALF = 25_000_000,
   parameter int unsigned STEP_HALF    = 2_500_000,
   parameter int unsigned MIN_HALF     = 2_500_000,
   parameter int unsigned MAX_HALF     = 100_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             speed_up,
   input  logic             speed_down,
   input  logic             rate_reset,
   input  logic             pause,
   output logic             clock_1Hz,
   output logic             tick,
   output logic [WIDTH-1:0] half_period
);

   localparam int unsigned WX = WIDTH + 1;
   localparam logic [WIDTH:0]   STEP_X  = WX'(STEP_HALF);
   localparam logic [WIDTH:0]   MIN_X   = WX'(MIN_HALF);
   localparam logic [WIDTH:0]   MAX_X   = WX'(MAX_HALF);
   localparam logic [WIDTH-1:0] DEFAULT = WIDTH'(DEFAULT_HALF);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} div_state_t;

   div_state_t       state, state_nxt;
   logic [1:0]       up_sync, dn_sync, rr_sync;
   logic             up_prev, dn_prev, rr_prev;
   logic             pause_meta;
   logic             up_edge, dn_edge, rr_edge;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic             clk_nxt, tick_nxt;
   logic [WIDTH-1:0] half_nxt;
   logic [WIDTH:0]   hp_dec, hp_inc;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         up_sync    <= '0;
         dn_sync    <= '0;
         rr_sync    <= '0;
         up_prev    <= 1'b0;
         dn_prev    <= 1'b0;
         rr_prev    <= 1'b0;
         pause_meta <= 1'b0;
      end else begin
         up_sync    <= {up_sync[0], speed_up};
         dn_sync    <= {dn_sync[0], speed_down};
         rr_sync    <= {rr_sync[0], rate_reset};
         up_prev    <= up_sync[1];
         dn_prev    <= dn_sync[1];
         rr_prev    <= rr_sync[1];
         pause_meta <= pause;
      end
   end

   assign up_edge = up_sync[1] & ~up_prev;
   assign dn_edge = dn_sync[1] & ~dn_prev;
   assign rr_edge = rr_sync[1] & ~rr_prev;

   // One extra bit of headroom: a borrow shows up in the MSB, a carry never reaches it.
   always_comb begin
      hp_dec   = {1'b0, half_period} - STEP_X;
      hp_inc   = {1'b0, half_period} + STEP_X;
      half_nxt = half_period;
      if (rr_edge) begin
         half_nxt = DEFAULT;
      end else if (up_edge && dn_edge) begin
         half_nxt = half_period;
      end else if (up_edge) begin
         half_nxt = (hp_dec[WIDTH] || (hp_dec < MIN_X)) ? MIN_X[WIDTH-1:0] : hp_dec[WIDTH-1:0];
      end else if (dn_edge) begin
         half_nxt = (hp_inc > MAX_X) ? MAX_X[WIDTH-1:0] : hp_inc[WIDTH-1:0];
      end
   end

   // The divider state register doubles as the second synchroniser stage for pause.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         cnt         <= '0;
         clock_1Hz   <= 1'b0;
         tick        <= 1'b0;
         half_period <= DEFAULT;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         clock_1Hz   <= clk_nxt;
         tick        <= tick_nxt;
         half_period <= half_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = pause_meta ? HOLD : RUN;
      cnt_nxt   = cnt;
      clk_nxt   = clock_1Hz;
      tick_nxt  = 1'b0;
      unique case (state)
         RUN: begin
            if (cnt >= half_period - WIDTH'(1)) begin
               cnt_nxt  = '0;
               clk_nxt  = ~clock_1Hz;
               tick_nxt = ~clock_1Hz;
            end else begin
               cnt_nxt  = cnt + WIDTH'(1);
            end
         end
         HOLD: begin
            cnt_nxt = cnt;
         end
         default: begin
            cnt_nxt = cnt;
         end
      endcase
   end

endmodule

// File: tb/tb_led_rate_gen.sv
// Self-checking bench for led_rate_gen using small rate parameters and a
// cycle-level reference model built from input sample history.
module tb_led_rate_gen;

   localparam int W       = 32;
   localparam int DEF     = 4;
   localparam int STEP    = 1;
   localparam int MIN_H   = 2;
   localparam int MAX_H   = 6;

   logic         clock = 1'b0;
   logic         reset;
   logic         speed_up, speed_down, rate_reset, pause;
   logic         clock_1Hz, tick;
   logic [W-1:0] half_period;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   int       m_hp, m_elapsed;
   bit       m_clk, m_tick;
   bit [2:0] h_up, h_dn, h_rr, h_pz;

   led_rate_gen #(
      .WIDTH(W), .DEFAULT_HALF(DEF), .STEP_HALF(STEP), .MIN_HALF(MIN_H), .MAX_HALF(MAX_H)
   ) dut (
      .clock(clock), .reset(reset), .speed_up(speed_up), .speed_down(speed_down),
      .rate_reset(rate_reset), .pause(pause), .clock_1Hz(clock_1Hz), .tick(tick),
      .half_period(half_period)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_hp = DEF; m_elapsed = 0; m_clk = 0; m_tick = 0;
      h_up = '0; h_dn = '0; h_rr = '0; h_pz = '0;
      cyc = 0;
   endfunction

   // One clock edge: a press is seen two samples late and counts only on its first high sample.
   function automatic void model_edge(input bit up, input bit dn, input bit rr, input bit pz);
      bit e_up, e_dn, e_rr;
      e_up = h_up[1] && !h_up[2];
      e_dn = h_dn[1] && !h_dn[2];
      e_rr = h_rr[1] && !h_rr[2];
      m_tick = 0;
      if (!h_pz[1]) begin
         m_elapsed++;
         if (m_elapsed >= m_hp) begin
            m_elapsed = 0;
            m_clk = !m_clk;
            m_tick = m_clk;
         end
      end
      if (e_rr) m_hp = DEF;
      else if (e_up && e_dn) m_hp = m_hp;
      else if (e_up) m_hp = (m_hp - STEP < MIN_H) ? MIN_H : m_hp - STEP;
      else if (e_dn) m_hp = (m_hp + STEP > MAX_H) ? MAX_H : m_hp + STEP;
      h_up = {h_up[1:0], up};
      h_dn = {h_dn[1:0], dn};
      h_rr = {h_rr[1:0], rr};
      h_pz = {h_pz[1:0], pz};
   endfunction

   task automatic step();
      bit up, dn, rr, pz;
      up = speed_up; dn = speed_down; rr = rate_reset; pz = pause;
      @(posedge clock);
      #1;
      cyc++;
      model_edge(up, dn, rr, pz);
      checks++;
      if (clock_1Hz !== m_clk) begin
         failures++;
         $display("FAIL model_clock_1Hz cyc=%0d got=%b exp=%b", cyc, clock_1Hz, m_clk);
      end
      checks++;
      if (tick !== m_tick) begin
         failures++;
         $display("FAIL model_tick cyc=%0d got=%b exp=%b", cyc, tick, m_tick);
      end
      checks++;
      if (half_period !== W'(m_hp)) begin
         failures++;
         $display("FAIL model_half_period cyc=%0d got=%0d exp=%0d", cyc, half_period, m_hp);
      end
   endtask

   task automatic run_until_tick(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_until_low(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (clock_1Hz === 1'b0) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic press(input bit up, input bit dn, input bit rr, input int hold_cycles, input int gap);
      speed_up = up; speed_down = dn; rate_reset = rr;
      repeat (hold_cycles) step();
      speed_up = 1'b0; speed_down = 1'b0; rate_reset = 1'b0;
      repeat (gap) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      speed_up = 1'b0; speed_down = 1'b0; rate_reset = 1'b0; pause = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (clock_1Hz !== 1'b0) begin failures++; $display("FAIL reset_clock_1Hz got=%b exp=0", clock_1Hz); end
      checks++;
      if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
      checks++;
      if (half_period !== W'(DEF)) begin failures++; $display("FAIL reset_half_period got=%0d exp=%0d", half_period, DEF); end
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      int first_tick, ticks, rises;
      bit prev_clk;
      first_tick = -1; ticks = 0; rises = 0; prev_clk = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (tick === 1'b1) begin
            ticks++;
            if (first_tick < 0) first_tick = i;
         end
         if (clock_1Hz === 1'b1 && !prev_clk) rises++;
         prev_clk = (clock_1Hz === 1'b1);
      end
      checks++;
      if (first_tick != 4) begin failures++; $display("FAIL free_first_tick got=%0d exp=4", first_tick); end
      checks++;
      if (ticks != 5) begin failures++; $display("FAIL free_tick_count got=%0d exp=5", ticks); end
      checks++;
      if (rises != 5) begin failures++; $display("FAIL free_rise_count got=%0d exp=5", rises); end
   endtask

   task automatic test_speed_up();
      int n1, n2;
      speed_up = 1'b1;
      step();
      speed_up = 1'b0;
      step();
      checks++;
      if (half_period !== W'(4)) begin failures++; $display("FAIL up_latency_early got=%0d exp=4", half_period); end
      step();
      checks++;
      if (half_period !== W'(3)) begin failures++; $display("FAIL up_latency_update got=%0d exp=3", half_period); end
      repeat (4) step();
      press(1, 0, 0, 1, 5);
      checks++;
      if (half_period !== W'(2)) begin failures++; $display("FAIL up_second got=%0d exp=2", half_period); end
      press(1, 0, 0, 1, 5);
      checks++;
      if (half_period !== W'(2)) begin failures++; $display("FAIL up_clamp got=%0d exp=2", half_period); end
      run_until_tick(20, n1);
      run_until_tick(20, n2);
      checks++;
      if (n1 < 0 || n2 != 4) begin failures++; $display("FAIL up_period got=%0d exp=4", n2); end
      press(0, 0, 1, 1, 5);
      press(1, 0, 0, 10, 5);
      checks++;
      if (half_period !== W'(3)) begin failures++; $display("FAIL up_held_once got=%0d exp=3", half_period); end
   endtask

   task automatic test_slow_down();
      press(0, 0, 1, 1, 5);
      press(0, 1, 0, 1, 5);
      checks++;
      if (half_period !== W'(5)) begin failures++; $display("FAIL down_first got=%0d exp=5", half_period); end
      press(0, 1, 0, 1, 5);
      checks++;
      if (half_period !== W'(6)) begin failures++; $display("FAIL down_second got=%0d exp=6", half_period); end
      press(0, 1, 0, 1, 5);
      checks++;
      if (half_period !== W'(6)) begin failures++; $display("FAIL down_clamp got=%0d exp=6", half_period); end
      press(1, 0, 1, 1, 5);
      checks++;
      if (half_period !== W'(4)) begin failures++; $display("FAIL rate_reset_priority got=%0d exp=4", half_period); end
   endtask

   task automatic test_simultaneous();
      press(1, 1, 0, 1, 5);
      checks++;
      if (half_period !== W'(4)) begin failures++; $display("FAIL both_at_default got=%0d exp=4", half_period); end
      press(0, 1, 0, 1, 5);
      press(1, 1, 0, 3, 5);
      checks++;
      if (half_period !== W'(5)) begin failures++; $display("FAIL both_at_five got=%0d exp=5", half_period); end
   endtask

   task automatic test_pause();
      int n;
      press(0, 0, 1, 1, 5);
      run_until_tick(20, n);
      checks++;
      if (n < 0) begin failures++; $display("FAIL pause_sync_tick got=%0d exp=positive", n); end
      pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (clock_1Hz !== 1'b1 || tick !== 1'b0) begin
            failures++;
            $display("FAIL pause_frozen i=%0d got=%b%b exp=10", i, clock_1Hz, tick);
         end
      end
      pause = 1'b0;
      run_until_low(10, n);
      checks++;
      if (n != 4) begin failures++; $display("FAIL pause_resume got=%0d exp=4", n); end
   endtask

   task automatic test_shrink_and_async_reset();
      int n;
      press(0, 0, 1, 1, 5);
      press(0, 1, 0, 1, 5);
      press(0, 1, 0, 1, 5);
      checks++;
      if (half_period !== W'(6)) begin failures++; $display("FAIL shrink_setup got=%0d exp=6", half_period); end
      run_until_tick(30, n);
      repeat (3) step();
      pause = 1'b1;
      repeat (3) step();
      press(1, 0, 0, 1, 5);
      press(1, 0, 0, 1, 5);
      press(1, 0, 0, 1, 5);
      checks++;
      if (half_period !== W'(3) || clock_1Hz !== 1'b1) begin
         failures++;
         $display("FAIL shrink_held got=%0d/%b exp=3/1", half_period, clock_1Hz);
      end
      pause = 1'b0;
      run_until_low(10, n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL shrink_wrap got=%0d exp=3", n); end
      run_until_tick(20, n);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (clock_1Hz !== 1'b0 || tick !== 1'b0 || half_period !== W'(DEF)) begin
         failures++;
         $display("FAIL async_reset got=%b/%b/%0d exp=0/0/%0d", clock_1Hz, tick, half_period, DEF);
      end
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (12) step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         speed_up   = ($urandom_range(0, 3) == 0);
         speed_down = ($urandom_range(0, 3) == 0);
         rate_reset = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         step();
      end
      pause = 1'b0;
      speed_up = 1'b0; speed_down = 1'b0; rate_reset = 1'b0;
      repeat (4) step();
      checks++;
      if (half_period < W'(MIN_H) || half_period > W'(MAX_H)) begin
         failures++;
         $display("FAIL random_range got=%0d exp=%0d..%0d", half_period, MIN_H, MAX_H);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_speed_up();
      test_slow_down();
      test_simultaneous();
      test_pause();
      test_shrink_and_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_rate_gen.md
# led_rate_gen

Programmable rate generator sitting directly upstream of the LED chaser FSM. It divides the 50 MHz board clock into the slow square wave `clock_1Hz` that steps the LED ping-pong sequence, plus a one-cycle tick strobe. Debounced-free button inputs, synchronised internally, let the user speed up, slow down, restore the default rate, or pause the LED sweep.

## Interface
- `WIDTH`, 32: width of the divider counter and half-period register.
- `DEFAULT_HALF`, 25_000_000: half-period in clock cycles after reset or `rate_reset`; gives 1 Hz at 50 MHz.
- `STEP_HALF`, 2_500_000: amount `half_period` changes per speed button press.
- `MIN_HALF`, 2_500_000: lower clamp on `half_period`, must be ≥ 1.
- `MAX_HALF`, 100_000_000: upper clamp on `half_period`, must fit in `WIDTH`.

Ports:
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: **asynchronous, active-high reset**.
- `speed_up` in 1: raw asynchronous button level; a rising edge shortens the period.
- `speed_down` in 1: raw asynchronous button level; a rising edge lengthens the period.
- `rate_reset` in 1: raw asynchronous button level; a rising edge restores `DEFAULT_HALF`.
- `pause` in 1: raw asynchronous level; while high, counting is frozen.
- `clock_1Hz` out 1: registered 50% duty square wave; feeds the LED FSM clock.
- `tick` out 1: registered one-cycle strobe, coincident with each 0→1 transition of `clock_1Hz`.
- `half_period` out WIDTH: current half-period register, for display.

## Operation
- **Input synchronisation.** Each of the four inputs passes through a 2-FF synchroniser.
- **Edge detection.** The three buttons use a registered previous-value flop: edge = sync & ~prev.
  - `pause` is used as a level after synchronisation.
- **Half-period update.** Evaluated every cycle in this priority order:
  1. A `rate_reset` edge loads `DEFAULT_HALF`.
  2. Otherwise, `speed_up` and `speed_down` edges in the same cycle leave the value unchanged.
  3. Otherwise, a `speed_up` edge loads max(`half_period` − `STEP_HALF`, `MIN_HALF`).
  4. Otherwise, a `speed_down` edge loads min(`half_period` + `STEP_HALF`, `MAX_HALF`).
- **Clamp arithmetic.** Compute in WIDTH+1 bits so it cannot wrap.
  - Subtraction underflow clamps to `MIN_HALF`.
  - Addition overflow clamps to `MAX_HALF`.
- **Divider states.** Two states, RUN and HOLD, selected by synchronised `pause`.
  - RUN, when `cnt` ≥ `half_period` − 1:
    - `cnt` ← 0.
    - `clock_1Hz` toggles.
    - `tick` ← 1 if `clock_1Hz` was 0, else 0.
  - RUN, otherwise: `cnt` increments and `tick` ← 0.
  - HOLD: `cnt` and `clock_1Hz` hold their values, and `tick` ← 0.
  - HOLD → RUN resumes the count from the held `cnt`.
- **Mid-count rate change.** A `half_period` change applies to the half-period in progress. The ≥ compare guarantees wrap on the next RUN cycle if `cnt` already exceeds the new limit; the counter never runs away.
- **Reset values.** On asynchronous `reset` assertion, immediately and regardless of clock:
  - `cnt` = 0, `clock_1Hz` = 0, `tick` = 0, `half_period` = `DEFAULT_HALF`.
  - All synchroniser and edge flops = 0.
  - Reset mid-operation discards all state.

## Timing
- **Steady state.**
  - `clock_1Hz` period = 2·`half_period` cycles, high for `half_period` cycles.
  - `tick` is high exactly one cycle per period.
- **After reset release.**
  - First `clock_1Hz` rise and first `tick` occur on the `half_period`-th rising edge after reset deasserts.
  - A new half-period starts every `half_period` edges after that.
- **Button latency.** A raw input that goes high before edge N gives a `half_period` update at edge N+2.
  - A held button produces exactly one update.
  - A new update requires a release (synchronised 0) and a fresh press.
- **Pause latency.** Pause takes effect 2 cycles after the raw change: the synchroniser delay.
- **Output timing.** All outputs are registered, with no combinational path from input to output.

## Test plan
All scenarios use parameters `DEFAULT_HALF`=4, `STEP_HALF`=1, `MIN_HALF`=2, `MAX_HALF`=6.
- **Reset and free run:** release reset, run 40 cycles.
  - `clock_1Hz` toggles every 4 cycles, with its first rise at edge 4.
  - `tick` pulses once per 8 cycles, aligned with each rise.
  - `half_period` = 4.
- **Speed up to clamp:** pulse `speed_up` 3 times, with gaps.
  - `half_period` goes 4→3→2→2.
  - The period becomes 4 cycles.
  - One held 10-cycle press causes only one decrement.
- **Slow down and rate reset:** pulse `speed_down` 3 times, then `rate_reset` together with `speed_up`.
  - `half_period` goes 5→6→6.
  - It then returns to 4, because `rate_reset` has priority.
- **Simultaneous up and down:** raise both in the same cycle.
  - `half_period` stays unchanged.
- **Pause:** assert `pause` for 20 cycles mid half-period, with `cnt` = 2.
  - `clock_1Hz` is frozen and `tick` = 0.
  - After release, the current half-period ends after the 2 remaining counts.
- **Shrink mid-count and async reset:**
  - At `cnt` = 5 with `half_period` = 6, press `speed_up` 3 times. The wrap occurs on the first RUN cycle after the update.
  - Assert `reset` between clock edges. All outputs go to reset values before the next edge.
